// File: rtl/mod_updown_counter_pkg.sv
// mod_updown_counter_pkg: shared end-behaviour constants and parameter legality helper
package mod_updown_counter_pkg;
    localparam bit CNT_WRAP = 1'b0;
    localparam bit CNT_SAT  = 1'b1;
    function automatic bit max_ok(input int w, input longint unsigned m);
        return w >= 1 && w < 64 && m >= 1 && m <= (64'd1 << w) - 1;
    endfunction
endpackage

// File: rtl/mod_updown_counter_if.sv
// mod_updown_counter_if: control and status bundle of one counter stage
interface mod_updown_counter_if #(parameter int W = 8);
    logic         clr;
    logic         load;
    logic [W-1:0] load_val;
    logic         en;
    logic         up;
    logic [W-1:0] out;
    logic         tc;
    logic         wrap;
    modport master (output clr, load, load_val, en, up, input out, tc, wrap);
    modport slave  (input clr, load, load_val, en, up, output out, tc, wrap);
endinterface

// File: rtl/mod_updown_counter_next.sv
// mod_updown_counter_next: next count, terminal count and wrap/blocked flag
module mod_updown_counter_next
    import mod_updown_counter_pkg::*;
#(
    parameter int           W        = 8,
    parameter logic [W-1:0] MAX      = '1,
    parameter bit           SATURATE = CNT_WRAP
) (
    input  logic [W-1:0] out,
    input  logic         en,
    input  logic         up,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] nxt,
    output logic         tc,
    output logic         wrap_next
);
    logic         at_max;
    logic         at_zero;
    logic         over;
    logic [W-1:0] ld;
    logic [W-1:0] inc;
    logic [W-1:0] dec;
    // A full-range MAX can never be exceeded, so the compares are elided there
    if (MAX == '1) begin : g_full
        assign over = 1'b0;
        assign ld   = load_val;
    end else begin : g_part
        assign over = out > MAX;
        assign ld   = load_val > MAX ? MAX : load_val;
    end
    assign at_max    = out == MAX;
    assign at_zero   = out == '0;
    assign tc        = en & (up ? at_max : at_zero);
    assign wrap_next = tc & ~clr & ~load;
    assign inc = (at_max && SATURATE) ? out : (at_max || over) ? '0 : out + W'(1);
    assign dec = at_zero ? (SATURATE ? out : MAX) : out - W'(1);
    assign nxt = clr ? '0 : load ? ld : en ? (up ? inc : dec) : out;
endmodule

// File: rtl/mod_updown_counter.sv
// mod_updown_counter: up/down modulo counter with clear, load, saturate option and cascade carry
module mod_updown_counter
    import mod_updown_counter_pkg::*;
#(
    parameter int              W        = 8,
    parameter longint unsigned MAX      = (64'd1 << W) - 1,
    parameter bit              SATURATE = CNT_WRAP
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mod_updown_counter_if.slave  bus
);
    localparam logic [W-1:0] MAX_W = W'(MAX);
    if (!max_ok(W, MAX)) begin : g_bad_max
        $error("mod_updown_counter: MAX must lie in 1..2**W-1");
    end
    logic [W-1:0] out_q;
    logic [W-1:0] nxt;
    logic         wrap_q;
    logic         wrap_next;
    mod_updown_counter_next #(.W(W), .MAX(MAX_W), .SATURATE(SATURATE)) u_next (
        .out       (out_q),
        .en        (bus.en),
        .up        (bus.up),
        .clr       (bus.clr),
        .load      (bus.load),
        .load_val  (bus.load_val),
        .nxt       (nxt),
        .tc        (bus.tc),
        .wrap_next (wrap_next)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q  <= '0;
            wrap_q <= 1'b0;
        end else begin
            out_q  <= nxt;
            wrap_q <= wrap_next;
        end
    end
    assign bus.out  = out_q;
    assign bus.wrap = wrap_q;
endmodule
